// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: types and timing constants shared by the WS2812B receiver and
// transmitter.
//   state_t  - receiver FSM states
//   pixel_t  - one 24-bit pixel word, first bit on the wire in bit 23
//   T0H/T1H/T_BIT/T_RESET_DEFAULT - nominal line timing in clk cycles at 12 MHz
package ws2812b_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  typedef logic [23:0] pixel_t;

  localparam int T0H             = 5;
  localparam int T1H             = 10;
  localparam int T_BIT           = 15;
  localparam int T_RESET_DEFAULT = 600;

endpackage

// File: rtl/ws2812b_rx_sync.sv
// ws2812b_sync: two-flop synchronizer for the asynchronous data line plus a
// registered copy used for edge detection.
//   clk, rst_n - clock, asynchronous active-low reset
//   din        - raw serial line
//   s          - synchronized line
//   rise, fall - single-cycle edge indications on s
module ws2812b_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic s_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      s      <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      meta   <= din;
      s      <= meta;
      s_prev <= s;
    end
  end

  assign rise = s & ~s_prev;
  assign fall = ~s & s_prev;

endmodule

// File: rtl/ws2812b_rx.sv
// ws2812b_rx: WS2812B receive decoder. Measures high-pulse widths on the
// synchronized line, assembles 24-bit pixels MSB first, counts pixels in a
// frame and detects the latch gap.
//   clk, rst_n   - clock, asynchronous active-low reset
//   serial_in    - WS2812B data line (asynchronous)
//   pixel_data   - last decoded pixel, bit 23 received first
//   pixel_valid  - one-cycle strobe qualifying pixel_data / pixel_index
//   pixel_index  - pixel position in the current frame
//   frame_done   - one-cycle strobe on latch gap after at least one bit
//   error        - one-cycle strobe on any protocol violation
//   fwd_out      - daisy-chain pass-through, only with WS2812B_RX_FWD_EN
//
// state | meaning
// SYNC  | waiting for T_RESET low cycles before trusting the line
// IDLE  | frame boundary, waiting for the first rising edge
// HIGH  | measuring a high pulse
// LOW   | between bits, watching for the latch gap
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int T_BIT_THRESH = 8,
  parameter int T_MIN_HIGH   = 2,
  parameter int T_MAX_HIGH   = 14,
  parameter int T_RESET      = T_RESET_DEFAULT,
  parameter int PIXELS       = 64,
  parameter int IDX_W        = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  output pixel_t           pixel_data,
  output logic             pixel_valid,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic             error
`ifdef WS2812B_RX_FWD_EN
  ,
  output logic             fwd_out
`endif
);

  // hcnt must hold T_MAX_HIGH+1 so an over-long pulse is seen before leaving HIGH
  localparam int HCNT_W = $clog2(T_MAX_HIGH + 2);
  localparam int LCNT_W = $clog2(T_RESET + 1);
  localparam int PCNT_W = $clog2(PIXELS + 1);

  localparam logic [HCNT_W-1:0] HMAX    = HCNT_W'(T_MAX_HIGH);
  localparam logic [HCNT_W-1:0] HMIN    = HCNT_W'(T_MIN_HIGH);
  localparam logic [HCNT_W-1:0] HTHR    = HCNT_W'(T_BIT_THRESH);
  localparam logic [LCNT_W-1:0] LRST_M1 = LCNT_W'(T_RESET - 1);
  localparam logic [PCNT_W-1:0] PIX_MAX = PCNT_W'(PIXELS);

  logic s, rise, fall;

  ws2812b_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (serial_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  state_t            state;
  logic [HCNT_W-1:0] hcnt;
  logic [LCNT_W-1:0] lcnt;
  logic [4:0]        bit_cnt;
  logic [PCNT_W-1:0] pixel_cnt;
  pixel_t            shreg;
  logic              full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SYNC;
      hcnt        <= '0;
      lcnt        <= '0;
      bit_cnt     <= '0;
      pixel_cnt   <= '0;
      shreg       <= '0;
      full        <= 1'b0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      full        <= 1'b0;

      // Pixel completion runs the cycle after the 24th bit shifted in.
      if (full) begin
        bit_cnt <= '0;
        if (pixel_cnt < PIX_MAX) begin
          pixel_data  <= shreg;
          pixel_index <= pixel_cnt[IDX_W-1:0];
          pixel_valid <= 1'b1;
          pixel_cnt   <= pixel_cnt + 1'b1;
        end else begin
          error <= 1'b1;
        end
      end

      // Error assignments below also drop pixel_valid so an error always wins.
      case (state)
        SYNC: begin
          if (s) begin
            lcnt <= '0;
          end else if (lcnt == LRST_M1) begin
            lcnt  <= '0;
            state <= IDLE;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end

        IDLE: begin
          bit_cnt   <= '0;
          pixel_cnt <= '0;
          if (rise) begin
            hcnt  <= HCNT_W'(1);
            state <= HIGH;
          end
        end

        HIGH: begin
          if (hcnt > HMAX) begin
            error       <= 1'b1;
            pixel_valid <= 1'b0;
            lcnt        <= '0;
            state       <= SYNC;
          end else if (fall) begin
            if (hcnt < HMIN) begin
              error       <= 1'b1;
              pixel_valid <= 1'b0;
              lcnt        <= '0;
              state       <= SYNC;
            end else begin
              shreg   <= {shreg[22:0], (hcnt >= HTHR)};
              bit_cnt <= bit_cnt + 1'b1;
              full    <= (bit_cnt == 5'd23);
              lcnt    <= LCNT_W'(1);
              state   <= LOW;
            end
          end else begin
            // bounded by the HMAX exit above, so no wrap
            hcnt <= hcnt + 1'b1;
          end
        end

        LOW: begin
          if (rise) begin
            hcnt  <= HCNT_W'(1);
            state <= HIGH;
          end else if (lcnt == LRST_M1) begin
            frame_done <= 1'b1;
            lcnt       <= '0;
            state      <= IDLE;
            if (bit_cnt != '0) begin
              error       <= 1'b1;
              pixel_valid <= 1'b0;
            end
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

`ifdef WS2812B_RX_FWD_EN
  // Gate opens once pixel 0 of this frame has been strobed, so the next board
  // in the chain sees only the pixels beyond the first.
  logic fwd_gate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_gate <= 1'b0;
      fwd_out  <= 1'b0;
    end else begin
      fwd_out <= s & fwd_gate;
      if (frame_done || error || (state == SYNC))
        fwd_gate <= 1'b0;
      else if (pixel_valid && (pixel_index == '0))
        fwd_gate <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ws2812b_rx.sv
module tb_ws2812b_rx;
  import ws2812b_pkg::*;

  localparam int PIXELS     = 64;
  localparam int BIT_THRESH = 8;
  localparam int MIN_HIGH   = 2;
  localparam int MAX_HIGH   = 14;
  localparam int RST_GAP    = 600;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial_in = 1'b0;
  pixel_t     pixel_data;
  logic       pixel_valid;
  logic [5:0] pixel_index;
  logic       frame_done;
  logic       error;
`ifdef WS2812B_RX_FWD_EN
  logic       fwd_out;
`endif

  ws2812b_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_index(pixel_index),
    .frame_done (frame_done),
    .error      (error)
`ifdef WS2812B_RX_FWD_EN
    ,
    .fwd_out    (fwd_out)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int     cyc = 0;
  pixel_t got_data[$];
  int     got_idx[$];
  int     n_err = 0, n_fd = 0, n_fd_err = 0, n_both = 0, n_fwd_hi = 0;
  int     last_valid_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pixel_valid) begin
        got_data.push_back(pixel_data);
        got_idx.push_back(int'(pixel_index));
        last_valid_cyc = cyc;
      end
      if (error) n_err++;
      if (frame_done) n_fd++;
      if (frame_done && error) n_fd_err++;
      if (pixel_valid && error) n_both++;
`ifdef WS2812B_RX_FWD_EN
      if (fwd_out) n_fwd_hi++;
`endif
    end
  end

  // ---------------- reference model (protocol level) ----------------
  pixel_t exp_data[$];
  int     exp_idx[$];
  int     exp_err = 0, exp_fd = 0, exp_fd_err = 0;
  int     m_idx = 0, m_bits = 0;
  bit     m_desync = 1'b1;
  bit     m_any = 1'b0;
  pixel_t m_word = '0;
  int     last_fall = 0;
  int     hi_acc = 0;

  task automatic model_bit(input int hw);
    if (!m_desync) begin
      if (hw < MIN_HIGH || hw > MAX_HIGH) begin
        exp_err++;
        m_desync = 1'b1;
        m_bits = 0;
      end else begin
        m_word = {m_word[22:0], (hw >= BIT_THRESH)};
        m_bits++;
        m_any = 1'b1;
        if (m_bits == 24) begin
          if (m_idx < PIXELS) begin
            exp_data.push_back(m_word);
            exp_idx.push_back(m_idx);
            m_idx++;
          end else begin
            exp_err++;
          end
          m_bits = 0;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_desync = 1'b1;
    m_bits = 0;
    m_idx = 0;
    m_any = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  task automatic send_bit(input int hw, input int lw);
    serial_in = 1'b1;
    hi_acc += hw;
    repeat (hw) @(negedge clk);
    serial_in = 1'b0;
    last_fall = cyc;
    model_bit(hw);
    repeat (lw) @(negedge clk);
  endtask

  task automatic send_pixel(input pixel_t p, input bit fixed);
    int hw, lw;
    for (int i = 23; i >= 0; i--) begin
      if (fixed) begin
        hw = p[i] ? T1H : T0H;
        lw = T_BIT - hw;
      end else begin
        hw = p[i] ? int'($urandom_range(BIT_THRESH, MAX_HIGH)) : int'($urandom_range(MIN_HIGH, BIT_THRESH - 1));
        lw = int'($urandom_range(3, 12));
      end
      send_bit(hw, lw);
    end
  endtask

  task automatic send_rand_bits(input int n);
    for (int i = 0; i < n; i++)
      send_bit(int'($urandom_range(MIN_HIGH, MAX_HIGH)), int'($urandom_range(3, 12)));
  endtask

  task automatic gap(input int n);
    serial_in = 1'b0;
    repeat (n) @(negedge clk);
    if (n >= RST_GAP) begin
      if (!m_desync && m_any) begin
        exp_fd++;
        if (m_bits != 0) begin
          exp_err++;
          exp_fd_err++;
        end
      end
      m_desync = 1'b0;
      m_bits = 0;
      m_idx = 0;
      m_any = 1'b0;
    end
  endtask

  task automatic compare_run(input string tag);
    check({tag, ".npix"}, got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      check($sformatf("%s.data%0d", tag, i), got_data[i], exp_data[i]);
      check($sformatf("%s.idx%0d", tag, i), got_idx[i], exp_idx[i]);
    end
    check({tag, ".err"}, n_err, exp_err);
    check({tag, ".fd"}, n_fd, exp_fd);
    check({tag, ".fd_err"}, n_fd_err, exp_fd_err);
    check({tag, ".valid_and_err"}, n_both, 0);
    got_data.delete(); got_idx.delete(); exp_data.delete(); exp_idx.delete();
    n_err = 0; n_fd = 0; n_fd_err = 0; n_both = 0;
    exp_err = 0; exp_fd = 0; exp_fd_err = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".data"}, pixel_data, 0);
    check({tag, ".valid"}, pixel_valid, 0);
    check({tag, ".index"}, pixel_index, 0);
    check({tag, ".fd"}, frame_done, 0);
    check({tag, ".err"}, error, 0);
  endtask

  initial begin
    int fwd_lo, fwd_hi;

    // reset values, line low
    serial_in = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // single pixel with nominal timing and latency measurement
    gap(620);
    send_pixel(24'hA53C0F, 1'b1);
    gap(650);
    check("latency", last_valid_cyc - last_fall, 4);
    compare_run("single");

    // line held high from reset, then a 3-pixel frame
    rst_n = 1'b0;
    serial_in = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (700) @(negedge clk);
    compare_run("hold_hi");
    gap(650);
    n_fwd_hi = 0;
    send_pixel(24'hFF0000, 1'b1);
    fwd_lo = hi_acc;
    send_pixel(24'h00FF00, 1'b1);
    send_pixel(24'h0000FF, 1'b1);
    fwd_hi = hi_acc;
    gap(650);
`ifdef WS2812B_RX_FWD_EN
    check("fwd_hi_cycles", n_fwd_hi, fwd_hi - fwd_lo);
`endif
    compare_run("three_pix");

    // randomized frames, one with a sub-threshold low gap between pixels
    for (int f = 0; f < 4; f++) begin
      int np;
      np = int'($urandom_range(1, 4));
      for (int p = 0; p < np; p++) begin
        send_pixel(pixel_t'($urandom), 1'b0);
        if (f == 1 && p == 0) gap(560);
      end
      gap(650);
      compare_run($sformatf("rand%0d", f));
    end

    // partial pixel at the latch gap, then a clean pixel
    send_rand_bits(12);
    gap(650);
    send_pixel(pixel_t'($urandom), 1'b0);
    gap(650);
    compare_run("partial");

    // glitch mid-pixel, following bits ignored until a full gap
    send_rand_bits(10);
    send_bit(1, 6);
    send_rand_bits(14);
    gap(650);
    send_pixel(pixel_t'($urandom), 1'b0);
    gap(650);
    compare_run("glitch");

    // over-long pulses: 20 cycles, then 15 (just over the limit), then a 14-wide pass
    send_rand_bits(5);
    send_bit(20, 6);
    gap(650);
    send_bit(15, 6);
    gap(650);
    send_bit(14, 6);
    send_pixel(pixel_t'($urandom), 1'b0);
    gap(650);
    compare_run("long_pulse");

    // overflow: 65 pixels in one frame
    for (int p = 0; p < 65; p++) send_pixel(pixel_t'($urandom), 1'b0);
    gap(650);
    compare_run("overflow");

    // reset asserted mid-pixel
    send_pixel(24'h123456, 1'b0);
    send_pixel(24'h89ABCD, 1'b0);
    send_rand_bits(10);
    compare_run("pre_rst");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs_zero("mid_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_pixel(pixel_t'($urandom), 1'b0);
    gap(650);
    send_pixel(pixel_t'($urandom), 1'b0);
    gap(650);
    compare_run("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
